// File: rtl/roach_infra_pkg.sv
// ---------------------------------------------------------------------------
// roach_infra_pkg
// Shared definitions for the board infrastructure layer: the sequencer state
// encoding, default parameter values and the width of saturating event
// counters.
// ---------------------------------------------------------------------------
package roach_infra_pkg;

   // Encodings are visible on seq_state, so software depends on them.
   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STABLE    = 3'd1,
      ST_IDLY_RST  = 3'd2,
      ST_WAIT_RDY  = 3'd3,
      ST_RELEASE   = 3'd4,
      ST_RUN       = 3'd5
   } seq_state_t;

   localparam int DEF_NUM_LOCKS          = 4;
   localparam int DEF_NUM_DOMAINS        = 4;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_IDELAY_RST_CYCLES  = 16;
   localparam int DEF_RDY_TIMEOUT        = 4096;
   localparam int DEF_DOMAIN_GAP         = 8;
   localparam int DEF_CNT_W              = 16;

   // Width of saturating event counters (lock_loss_cnt).
   localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/roach_sync_2ff.sv
// ---------------------------------------------------------------------------
// roach_sync_2ff
// Two-flop synchroniser for asynchronous level inputs, W bits wide. Each bit
// is synchronised independently; there is no cross-bit coherency.
// Ports:
//   clk   destination clock
//   rst_n asynchronous active-low reset, clears both stages to 0
//   d     asynchronous input
//   q     synchronised output, 2 cycles of latency
// ---------------------------------------------------------------------------
module roach_sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/roach_clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// roach_clk_rst_sequencer
// Power-up / recovery sequencer. Qualifies PLL/DCM locks, pulses the
// IDELAYCTRL reset, waits for idelay_rdy, then releases domain resets in
// ascending order. Lock loss after qualification restarts the sequence and
// is counted.
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   pll_lock            lock flags (async, synchronised here)
//   lock_mask           1 = lock bit participates (quasi-static)
//   idelay_rdy          IDELAYCTRL ready (async, synchronised here)
//   restart             single-cycle software restart request
//   idelay_rst          IDELAYCTRL reset, active high
//   domain_rst          per-domain resets, active high
//   all_ready           high only in RUN
//   seq_state           current state encoding
//   lock_loss_cnt       saturating lock-loss event count
//   timeout_err         sticky idelay_rdy timeout flag, cleared by restart
// ---------------------------------------------------------------------------
module roach_clk_rst_sequencer
   import roach_infra_pkg::*;
#(
   parameter int NUM_LOCKS          = DEF_NUM_LOCKS,
   parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int IDELAY_RST_CYCLES  = DEF_IDELAY_RST_CYCLES,
   parameter int RDY_TIMEOUT        = DEF_RDY_TIMEOUT,
   parameter int DOMAIN_GAP         = DEF_DOMAIN_GAP,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [NUM_LOCKS-1:0]  pll_lock,
   input  logic [NUM_LOCKS-1:0]  lock_mask,
   input  logic                  idelay_rdy,
   input  logic                  restart,
   output logic                  idelay_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                  all_ready,
   output logic [2:0]            seq_state,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
   output logic                  timeout_err
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLY_LAST   = CNT_W'(IDELAY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] RDY_LAST    = CNT_W'(RDY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'((NUM_DOMAINS - 1) * DOMAIN_GAP);

   logic [NUM_LOCKS-1:0]   lock_sync;
   logic                   rdy_sync;
   logic                   locks_ok;

   seq_state_t             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   loss_evt;
   logic                   tmo_evt;

   logic                   idelay_rst_next;
   logic                   all_ready_next;
   logic [NUM_DOMAINS-1:0] domain_open;
   logic [NUM_DOMAINS-1:0] domain_rst_next;
   logic [LOSS_CNT_W-1:0]  lock_loss_cnt_next;
   logic                   timeout_err_next;

   roach_sync_2ff #(.W(NUM_LOCKS)) u_sync_lock (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (pll_lock),
      .q     (lock_sync)
   );

   roach_sync_2ff #(.W(1)) u_sync_rdy (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (idelay_rdy),
      .q     (rdy_sync)
   );

   // Masked-out bits are forced true, so an all-zero mask always qualifies.
   assign locks_ok = &(lock_sync | ~lock_mask);

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= ST_WAIT_LOCK;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic. The counter restarts at 0 on every transition and is
   // held at 0 in states that do not time anything.
   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      loss_evt   = 1'b0;
      tmo_evt    = 1'b0;
      if (restart) begin
         state_next = ST_WAIT_LOCK;
      end else begin
         case (state_reg)
            ST_WAIT_LOCK: begin
               if (locks_ok) state_next = ST_STABLE;
            end
            ST_STABLE: begin
               // Dropping out before qualification is not a lock-loss event.
               if (!locks_ok)                 state_next = ST_WAIT_LOCK;
               else if (cnt_reg == STABLE_LAST) state_next = ST_IDLY_RST;
               else                           cnt_next   = cnt_reg + CNT_W'(1);
            end
            ST_IDLY_RST: begin
               if (!locks_ok) begin
                  state_next = ST_WAIT_LOCK;
                  loss_evt   = 1'b1;
               end else if (cnt_reg == IDLY_LAST) begin
                  state_next = ST_WAIT_RDY;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_WAIT_RDY: begin
               // Timeout outranks a coincident ready.
               if (!locks_ok) begin
                  state_next = ST_WAIT_LOCK;
                  loss_evt   = 1'b1;
               end else if (cnt_reg == RDY_LAST) begin
                  state_next = ST_IDLY_RST;
                  tmo_evt    = 1'b1;
               end else if (rdy_sync) begin
                  state_next = ST_RELEASE;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (!locks_ok) begin
                  state_next = ST_WAIT_LOCK;
                  loss_evt   = 1'b1;
               end else if (cnt_reg == REL_LAST) begin
                  state_next = ST_RUN;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!locks_ok) begin
                  state_next = ST_WAIT_LOCK;
                  loss_evt   = 1'b1;
               end
            end
            default: state_next = ST_WAIT_LOCK;
         endcase
      end
   end

   // A domain is open in RUN, or in RELEASE once the counter has reached its
   // slot. The counter only rises within RELEASE, so an opened domain stays
   // open until the sequence leaves RELEASE/RUN.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
         localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi * DOMAIN_GAP);
         assign domain_open[gi] = (state_next == ST_RUN) ||
                                  ((state_next == ST_RELEASE) && (cnt_next >= SLOT));
      end
   endgenerate

   // Output logic: decoded from the next state so the registered outputs
   // line up with seq_state.
   always_comb begin
      idelay_rst_next    = (state_next == ST_IDLY_RST);
      all_ready_next     = (state_next == ST_RUN);
      domain_rst_next    = ~domain_open;
      lock_loss_cnt_next = lock_loss_cnt;
      if (loss_evt && (lock_loss_cnt != {LOSS_CNT_W{1'b1}}))
         lock_loss_cnt_next = lock_loss_cnt + LOSS_CNT_W'(1);
      timeout_err_next = timeout_err;
      if (restart)      timeout_err_next = 1'b0;
      else if (tmo_evt) timeout_err_next = 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idelay_rst    <= 1'b0;
         all_ready     <= 1'b0;
         domain_rst    <= '1;
         lock_loss_cnt <= '0;
         timeout_err   <= 1'b0;
      end else begin
         idelay_rst    <= idelay_rst_next;
         all_ready     <= all_ready_next;
         domain_rst    <= domain_rst_next;
         lock_loss_cnt <= lock_loss_cnt_next;
         timeout_err   <= timeout_err_next;
      end
   end

   assign seq_state = state_reg;

endmodule

// File: tb/tb_roach_clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_roach_clk_rst_sequencer
// Scoreboard bench: stimulus pushes expected output snapshots tagged with
// the cycle at which they must appear; a monitor on the falling edge pops and
// compares them. Cycle n means "after the n-th rising clock edge".
// ---------------------------------------------------------------------------
module tb_roach_clk_rst_sequencer;

   logic       clk = 1'b0;
   logic       sys_rst_n;
   logic [1:0] pll_lock;
   logic [1:0] lock_mask;
   logic       idelay_rdy;
   logic       restart;
   logic       idelay_rst;
   logic [2:0] domain_rst;
   logic       all_ready;
   logic [2:0] seq_state;
   logic [7:0] lock_loss_cnt;
   logic       timeout_err;

   roach_clk_rst_sequencer #(
      .NUM_LOCKS          (2),
      .NUM_DOMAINS        (3),
      .LOCK_STABLE_CYCLES (8),
      .IDELAY_RST_CYCLES  (4),
      .RDY_TIMEOUT        (16),
      .DOMAIN_GAP         (2),
      .CNT_W              (16)
   ) dut (
      .sys_clk       (clk),
      .sys_rst_n     (sys_rst_n),
      .pll_lock      (pll_lock),
      .lock_mask     (lock_mask),
      .idelay_rdy    (idelay_rdy),
      .restart       (restart),
      .idelay_rst    (idelay_rst),
      .domain_rst    (domain_rst),
      .all_ready     (all_ready),
      .seq_state     (seq_state),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         cyc;
      string      tag;
      logic [2:0] st;
      logic [2:0] dom;
      logic       idr;
      logic       rdy;
      logic [7:0] llc;
      logic       terr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
      end
   endtask

   task automatic push_exp(input int c, input string tag, input logic [2:0] st,
                           input logic [2:0] dom, input logic idr, input logic rdy,
                           input logic [7:0] llc, input logic terr);
      exp_t e;
      e.cyc = c; e.tag = tag; e.st = st; e.dom = dom;
      e.idr = idr; e.rdy = rdy; e.llc = llc; e.terr = terr;
      sb.push_back(e);
   endtask

   // Full bring-up timeline relative to the cycle s at which STABLE is
   // entered: 8 STABLE cycles, 4 IDLY_RST cycles, one WAIT_RDY cycle (ready
   // already synchronised), RELEASE with counter 0..4, then RUN.
   task automatic push_seq(input int s, input logic [7:0] llc, input logic terr,
                           input int upto, input string tg);
      push_exp(s, {tg, "_stable"}, 3'd1, 3'b111, 1'b0, 1'b0, llc, terr);
      if (upto >= 7)  push_exp(s + 7,  {tg, "_stable_end"}, 3'd1, 3'b111, 1'b0, 1'b0, llc, terr);
      if (upto >= 8)  push_exp(s + 8,  {tg, "_idly"},       3'd2, 3'b111, 1'b1, 1'b0, llc, terr);
      if (upto >= 11) push_exp(s + 11, {tg, "_idly_end"},   3'd2, 3'b111, 1'b1, 1'b0, llc, terr);
      if (upto >= 12) push_exp(s + 12, {tg, "_wrdy"},       3'd3, 3'b111, 1'b0, 1'b0, llc, terr);
      if (upto >= 13) push_exp(s + 13, {tg, "_rel0"},       3'd4, 3'b110, 1'b0, 1'b0, llc, terr);
      if (upto >= 15) push_exp(s + 15, {tg, "_rel1"},       3'd4, 3'b100, 1'b0, 1'b0, llc, terr);
      if (upto >= 17) push_exp(s + 17, {tg, "_rel2"},       3'd4, 3'b000, 1'b0, 1'b0, llc, terr);
      if (upto >= 18) push_exp(s + 18, {tg, "_run"},        3'd5, 3'b000, 1'b0, 1'b1, llc, terr);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   // Monitor: compares every expectation due at this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc != cyc) begin
            check_val({mon_e.tag, "_cycle"}, cyc, mon_e.cyc);
         end else begin
            $display("chk %-16s cyc=%0d st=%0d dom=%b idr=%b rdy=%b llc=%0d terr=%b",
                     mon_e.tag, cyc, seq_state, domain_rst, idelay_rst, all_ready,
                     lock_loss_cnt, timeout_err);
            check_val({mon_e.tag, "_state"},   seq_state,     mon_e.st);
            check_val({mon_e.tag, "_dom"},     domain_rst,    mon_e.dom);
            check_val({mon_e.tag, "_idr"},     idelay_rst,    mon_e.idr);
            check_val({mon_e.tag, "_ready"},   all_ready,     mon_e.rdy);
            check_val({mon_e.tag, "_losscnt"}, lock_loss_cnt, mon_e.llc);
            check_val({mon_e.tag, "_tmoerr"},  timeout_err,   mon_e.terr);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int s;
      sys_rst_n  = 1'b0;
      pll_lock   = 2'b00;
      lock_mask  = 2'b11;
      idelay_rdy = 1'b0;
      restart    = 1'b0;
      tick(2);
      push_exp(cyc, "reset", 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
      tick(1);
      sys_rst_n  = 1'b1;
      idelay_rdy = 1'b1;
      tick(2);

      // Clean bring-up
      pll_lock = 2'b11; b = cyc;
      push_exp(b + 2, "s1_wait", 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
      push_seq(b + 3, 8'd0, 1'b0, 18, "s1");
      wait_until(b + 22);

      // Lock loss in RUN
      pll_lock = 2'b10; b = cyc;
      push_exp(b + 2, "s3_still_run", 3'd5, 3'b000, 1'b0, 1'b1, 8'd0, 1'b0);
      push_exp(b + 3, "s3_lost",      3'd0, 3'b111, 1'b0, 1'b0, 8'd1, 1'b0);
      wait_until(b + 4);

      // Lock returns; one-cycle glitch on lock[1] at STABLE count 5
      pll_lock = 2'b11; b = cyc;
      push_exp(b + 3, "s2_stable", 3'd1, 3'b111, 1'b0, 1'b0, 8'd1, 1'b0);
      push_exp(b + 8, "s2_cnt5",   3'd1, 3'b111, 1'b0, 1'b0, 8'd1, 1'b0);
      wait_until(b + 6);
      pll_lock = 2'b01;
      tick(1);
      pll_lock = 2'b11;
      push_exp(b + 9, "s2_glitch", 3'd0, 3'b111, 1'b0, 1'b0, 8'd1, 1'b0);
      push_seq(b + 10, 8'd1, 1'b0, 18, "s2");
      wait_until(b + 29);

      // 300 further losses; first from RUN, the rest from IDLY_RST
      for (int i = 0; i < 300; i++) begin
         pll_lock = 2'b10;
         tick(3);
         if (i == 99)  push_exp(cyc, "s3_loss101", 3'd0, 3'b111, 1'b0, 1'b0, 8'd101, 1'b0);
         if (i == 254) push_exp(cyc, "s3_sat",     3'd0, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
         pll_lock = 2'b11;
         tick(11);
      end
      b = cyc;
      push_exp(b,      "s3_idly", 3'd2, 3'b111, 1'b1, 1'b0, 8'd255, 1'b0);
      push_exp(b + 4,  "s3_wrdy", 3'd3, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      push_exp(b + 5,  "s3_rel",  3'd4, 3'b110, 1'b0, 1'b0, 8'd255, 1'b0);
      push_exp(b + 10, "s3_run",  3'd5, 3'b000, 1'b0, 1'b1, 8'd255, 1'b0);
      wait_until(b + 11);

      // Timeout with idelay_rdy low
      idelay_rdy = 1'b0;
      tick(3);
      restart = 1'b1; b = cyc;
      tick(1);
      restart = 1'b0;
      push_exp(b + 1, "s5_restart", 3'd0, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      s = b + 2;
      push_exp(s,      "s5_stable",    3'd1, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      push_exp(s + 8,  "s5_idly",      3'd2, 3'b111, 1'b1, 1'b0, 8'd255, 1'b0);
      push_exp(s + 12, "s5_wrdy",      3'd3, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      push_exp(s + 27, "s5_wrdy_last", 3'd3, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      push_exp(s + 28, "s5_tmo",       3'd2, 3'b111, 1'b1, 1'b0, 8'd255, 1'b1);
      push_exp(s + 31, "s5_idly2_end", 3'd2, 3'b111, 1'b1, 1'b0, 8'd255, 1'b1);
      push_exp(s + 32, "s5_wrdy2",     3'd3, 3'b111, 1'b0, 1'b0, 8'd255, 1'b1);
      wait_until(s + 33);
      idelay_rdy = 1'b1;
      push_exp(s + 36, "s5_rel0", 3'd4, 3'b110, 1'b0, 1'b0, 8'd255, 1'b1);
      push_exp(s + 38, "s5_rel1", 3'd4, 3'b100, 1'b0, 1'b0, 8'd255, 1'b1);
      push_exp(s + 40, "s5_rel2", 3'd4, 3'b000, 1'b0, 1'b0, 8'd255, 1'b1);
      push_exp(s + 41, "s5_run",  3'd5, 3'b000, 1'b0, 1'b1, 8'd255, 1'b1);
      wait_until(s + 42);
      restart = 1'b1; b = cyc;
      tick(1);
      restart = 1'b0;
      push_exp(b + 1, "s5_clear", 3'd0, 3'b111, 1'b0, 1'b0, 8'd255, 1'b0);
      tick(2);

      // Mask: lock[1] ignored, and toggled throughout
      lock_mask = 2'b01;
      pll_lock  = 2'b01;
      restart   = 1'b1; b = cyc;
      tick(1);
      restart = 1'b0;
      push_seq(b + 2, 8'd255, 1'b0, 18, "s4");
      while (cyc < b + 21) begin
         pll_lock[1] = ~pll_lock[1];
         tick(1);
      end

      // Async reset in the middle of RELEASE
      restart = 1'b1; b = cyc;
      tick(1);
      restart = 1'b0;
      s = b + 2;
      push_seq(s, 8'd255, 1'b0, 15, "s6");
      wait_until(s + 16);
      sys_rst_n = 1'b0;
      push_exp(cyc, "s6_async", 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
      tick(2);
      push_exp(cyc, "s6_hold", 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
      tick(1);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
      if (sb.size() != 0) check_val("sb_drain", sb.size(), 0);
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
